ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded fields and operands that register holds.
- While the operation runs, it raises a stall that freezes the ID/EX register and the upstream stages.
- Produces the result and writeback destination for the EX/MEM register.

Parameters:
- XLEN, 32, operand/result width.
- XREG_ADDRWIDTH, 5, register address width.
- ITER, 32, iterations per mul/div (must equal XLEN).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  kill in-flight op (branch/exception).
- opcode_in  input  7  from ID/EX.
- func3_in  input  3  from ID/EX.
- func7_in  input  7  from ID/EX.
- rs1_in  input  XLEN  operand A.
- rs2_in  input  XLEN  operand B.
- rd_en_in  input  1  writeback enable of the held instruction.
- rd_addr_in  input  XREG_ADDRWIDTH  destination.
- stall_out  output  1  freeze ID/EX and upstream stages.
- busy  output  1  FSM not IDLE.
- result_valid  output  1  result/rd fields valid this cycle.
- result  output  XLEN  mul/div result.
- rd_en_out  output  1  writeback enable, qualified by result_valid.
- rd_addr_out  output  XREG_ADDRWIDTH  destination.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, counter=0.
  - result, rd_addr_out = 0.
  - result_valid, rd_en_out = 0.
  - All internal operand/accumulator registers = 0.
- M-op detect: is_m = (opcode_in==7'b0110011) && (func7_in==7'b0000001). func3 selects the op:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- stall_out is combinational: (state==IDLE && is_m && !flush) || state==BUSY. It is low in DONE.
- busy = (state!=IDLE).
- FSM states and transitions:
  - IDLE, with is_m && !flush: latch func3, rd_en_in, rd_addr_in. Latch the absolute values of the operands:
    - signed: rs1 for MULH/MULHSU/DIV/REM; rs2 for MULH/DIV/REM.
    - unsigned otherwise.
    - Record the result sign.
  - IDLE, divide special cases: go directly to DONE (1 stall cycle).
    - rs2==0: quotient=all ones, remainder=rs1.
    - Signed overflow (rs1==0x80000000, rs2==0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
  - IDLE, all other cases: go to BUSY with counter=0.
  - BUSY, multiply: shift-add, one multiplier bit per cycle into a 2*XLEN accumulator.
  - BUSY, divide: restoring division, one quotient bit per cycle, with an XLEN+1-bit partial remainder.
  - BUSY: counter increments each cycle. At counter==ITER-1, go to DONE.
  - DONE: result_valid=1, rd_en_out=latched rd_en, rd_addr_out=latched addr.
    - result: negated if the sign flag is set.
    - MUL takes the low XLEN bits; MULH* take the high XLEN bits.
    - Negation is applied to the full 2*XLEN product before the high half is selected.
    - Remainder takes the dividend's sign.
    - Next cycle: return to IDLE unconditionally.
    - No restart in DONE, because ID/EX still holds the same instruction that cycle.
- Outside DONE: result_valid=0, rd_en_out=0. result and rd_addr_out hold their last values.
- Latency:
  - Normal op: stall high for 1+ITER=33 cycles; result_valid in cycle 34 after the op first appears.
  - Special-case divide: stall high 1 cycle; result in cycle 2.
- flush:
  - In BUSY or DONE: next state is IDLE, result_valid=0 next cycle, no writeback.
  - In IDLE: suppresses start and stall.
- Non-M opcodes in IDLE: no stall, no state change, result_valid=0.
- Back-to-back M-ops: the second starts in the IDLE cycle after DONE.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD) -> stall_out high exactly 33 cycles; next cycle result_valid=1, result=0xFFFFFFEB, rd_addr_out echoes input, rd_en_out=1.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> result=0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU rs1=-1, rs2=2 -> 0xFFFFFFFF.
- DIV -7/2 -> result=0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero: DIVU x/0 -> 0xFFFFFFFF; REM 5/0 -> 5. Overflow DIV 0x80000000/-1 -> 0x80000000, REM -> 0. Each with stall of 1 cycle.
- Assert flush at BUSY counter=10 -> state IDLE next cycle, stall_out low, no result_valid pulse. Assert async rst mid-BUSY -> all outputs 0 immediately.
- Two consecutive M-ops (MUL then DIV) -> two result_valid pulses, separated by one IDLE cycle. ADD opcode (func7=0) -> stall_out never asserted.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Bundle between the ID/EX register, the iterative mul/div unit and the EX/MEM register.
interface ex_muldiv_if #(
  parameter int XLEN           = 32,
  parameter int XREG_ADDRWIDTH = 5
);
  logic                      flush;
  logic [6:0]                opcode_in;
  logic [2:0]                func3_in;
  logic [6:0]                func7_in;
  logic [XLEN-1:0]           rs1_in;
  logic [XLEN-1:0]           rs2_in;
  logic                      rd_en_in;
  logic [XREG_ADDRWIDTH-1:0] rd_addr_in;
  logic                      stall_out;
  logic                      busy;
  logic                      result_valid;
  logic [XLEN-1:0]           result;
  logic                      rd_en_out;
  logic [XREG_ADDRWIDTH-1:0] rd_addr_out;

  modport master (
    output flush, opcode_in, func3_in, func7_in, rs1_in, rs2_in, rd_en_in, rd_addr_in,
    input  stall_out, busy, result_valid, result, rd_en_out, rd_addr_out
  );

  modport slave (
    input  flush, opcode_in, func3_in, func7_in, rs1_in, rs2_in, rd_en_in, rd_addr_in,
    output stall_out, busy, result_valid, result, rd_en_out, rd_addr_out
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide for the EX stage: shift-add multiply, restoring divide,
// one bit per cycle on operand magnitudes, sign fixed up when the result is written.
//
// state | meaning
// IDLE  | waiting for an M-op; start cycle stalls the pipe, div special cases finish here
// BUSY  | one multiplier/quotient bit per cycle, counter runs 0..ITER-1
// DONE  | result and writeback fields valid for one cycle, then back to IDLE
module ex_muldiv #(
  parameter int XLEN           = 32,
  parameter int XREG_ADDRWIDTH = 5,
  parameter int ITER           = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);
  localparam int              CW      = $clog2(ITER);
  localparam logic [CW-1:0]   LAST    = CW'(ITER - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_next;

  logic [2:0]                op_q;
  logic                      rd_en_q;
  logic [XREG_ADDRWIDTH-1:0] rd_addr_q;
  logic                      neg_q;
  logic [XLEN-1:0]           opb_q;
  logic [2*XLEN-1:0]         acc_q;
  logic [XLEN-1:0]           rem_q;
  logic [CW-1:0]             count_q;

  logic            is_m, start, is_div, a_signed, b_signed, sign_a, sign_b;
  logic            div_zero, div_ovf, special, neg_start;
  logic [XLEN-1:0] abs_a, abs_b, special_res;

  assign is_m   = (bus.opcode_in == 7'b0110011) && (bus.func7_in == 7'b0000001);
  assign start  = (state == IDLE) && is_m && !bus.flush;
  assign is_div = bus.func3_in[2];

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (bus.func3_in)
      3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
  end

  assign sign_a    = a_signed & bus.rs1_in[XLEN-1];
  assign sign_b    = b_signed & bus.rs2_in[XLEN-1];
  assign abs_a     = sign_a ? -bus.rs1_in : bus.rs1_in;
  assign abs_b     = sign_b ? -bus.rs2_in : bus.rs2_in;
  // remainder follows the dividend; everything else follows the product/quotient sign
  assign neg_start = (is_div && bus.func3_in[1]) ? sign_a : (sign_a ^ sign_b);

  assign div_zero    = is_div && (bus.rs2_in == '0);
  assign div_ovf     = is_div && !bus.func3_in[0] && (bus.rs1_in == MIN_NEG) && (bus.rs2_in == '1);
  assign special     = div_zero || div_ovf;
  assign special_res = div_ovf  ? (bus.func3_in[1] ? '0 : MIN_NEG)
                                : (bus.func3_in[1] ? bus.rs1_in : '1);

  logic [XLEN:0]     mul_sum, rem_shift, rem_diff;
  logic [XLEN-1:0]   rem_step, div_sel, final_res;
  logic [2*XLEN-1:0] acc_step, prod_signed;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({(XLEN+1){acc_q[0]}} & {1'b0, opb_q});
    rem_shift = {rem_q, acc_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, opb_q};
    rem_step  = rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
    if (op_q[2])
      acc_step = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~rem_diff[XLEN]};
    else
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    prod_signed = neg_q ? -acc_step : acc_step;
    div_sel     = op_q[1] ? rem_step : acc_step[XLEN-1:0];
    if (op_q[2])
      final_res = neg_q ? -div_sel : div_sel;
    else if (op_q == 3'b000)
      final_res = prod_signed[XLEN-1:0];
    else
      final_res = prod_signed[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.stall_out = 1'b0;
    case (state)
      IDLE: if (start) begin
        bus.stall_out = 1'b1;
        state_next    = special ? DONE : BUSY;
      end
      BUSY: begin
        bus.stall_out = 1'b1;
        if (bus.flush)            state_next = IDLE;
        else if (count_q == LAST) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q             <= '0;
      rd_en_q          <= 1'b0;
      rd_addr_q        <= '0;
      neg_q            <= 1'b0;
      opb_q            <= '0;
      acc_q            <= '0;
      rem_q            <= '0;
      count_q          <= '0;
      bus.result       <= '0;
      bus.result_valid <= 1'b0;
      bus.rd_en_out    <= 1'b0;
      bus.rd_addr_out  <= '0;
    end else begin
      bus.result_valid <= 1'b0;
      bus.rd_en_out    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q      <= bus.func3_in;
          rd_en_q   <= bus.rd_en_in;
          rd_addr_q <= bus.rd_addr_in;
          neg_q     <= neg_start;
          opb_q     <= is_div ? abs_b : abs_a;
          acc_q     <= {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
          rem_q     <= '0;
          count_q   <= '0;
          if (special) begin
            bus.result       <= special_res;
            bus.result_valid <= 1'b1;
            bus.rd_en_out    <= bus.rd_en_in;
            bus.rd_addr_out  <= bus.rd_addr_in;
          end
        end
        BUSY: if (!bus.flush) begin
          acc_q   <= acc_step;
          rem_q   <= rem_step;
          count_q <= count_q + 1'b1;
          if (count_q == LAST) begin
            bus.result       <= final_res;
            bus.result_valid <= 1'b1;
            bus.rd_en_out    <= rd_en_q;
            bus.rd_addr_out  <= rd_addr_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, randomized ops against an
// arithmetic reference model, and hand sequences for flush, reset and back-to-back ops.
module tb_ex_muldiv;
  localparam logic [6:0] OP_R = 7'b0110011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ex_muldiv_if #(.XLEN(32), .XREG_ADDRWIDTH(5)) bus ();

  ex_muldiv #(.XLEN(32), .XREG_ADDRWIDTH(5), .ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] pa, pb;
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin
        pa = {{32{a[31]}}, a}; pb = {{32{b[31]}}, b}; p = pa * pb; return p[63:32];
      end
      3'd2: begin
        pa = {{32{a[31]}}, a}; pb = {32'b0, b}; p = pa * pb; return p[63:32];
      end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic rden);
    bus.opcode_in  = OP_R;
    bus.func7_in   = 7'b0000001;
    bus.func3_in   = f3;
    bus.rs1_in     = a;
    bus.rs2_in     = b;
    bus.rd_addr_in = rd;
    bus.rd_en_in   = rden;
  endtask

  task automatic drive_nop();
    bus.opcode_in  = 7'b0010011;
    bus.func7_in   = 7'b0000000;
    bus.func3_in   = 3'b000;
    bus.rs1_in     = 32'h0;
    bus.rs2_in     = 32'h0;
    bus.rd_addr_in = 5'd0;
    bus.rd_en_in   = 1'b0;
  endtask

  // Called at negedge+1 of the op's first cycle; returns at negedge+1 of the valid cycle.
  task automatic wait_result(output int stalls, output int vcyc, output logic [31:0] r,
                             output logic [4:0] ra, output logic re);
    stalls = 0; vcyc = 0; r = '0; ra = '0; re = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (bus.result_valid) begin
        vcyc = i; r = bus.result; ra = bus.rd_addr_out; re = bus.rd_en_out;
        break;
      end
      if (bus.stall_out) stalls++;
      @(negedge clk); #1;
    end
  endtask

  task automatic run_and_check(input string tag, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp,
                               input logic [4:0] rd, input logic rden);
    int stalls, vcyc;
    logic [31:0] r;
    logic [4:0]  ra;
    logic        re;
    bit          sp;
    sp = is_special(f3, a, b);
    @(negedge clk);
    drive_m(f3, a, b, rd, rden);
    #1;
    wait_result(stalls, vcyc, r, ra, re);
    drive_nop();
    check({tag, "_result"}, r, exp);
    check({tag, "_stall_cycles"}, 32'(stalls), sp ? 32'd1 : 32'd33);
    check({tag, "_valid_cycle"}, 32'(vcyc), sp ? 32'd2 : 32'd34);
    check({tag, "_rd_addr"}, {27'b0, ra}, {27'b0, rd});
    check({tag, "_rd_en"}, {31'b0, re}, {31'b0, rden});
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[16];
    int   stalls, vcyc, seen;
    logic [31:0] r, r2;
    logic [4:0]  ra;
    logic        re;

    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2};
    vecs[8]  = '{3'd5, 32'd1234,     32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'd5};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[12] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[13] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
    vecs[14] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[15] = '{3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};

    bus.flush = 1'b0;
    drive_nop();
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_valid", {31'b0, bus.result_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_rd_addr", {27'b0, bus.rd_addr_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("idle_stall", {31'b0, bus.stall_out}, 32'd0);
    check("idle_rd_en", {31'b0, bus.rd_en_out}, 32'd0);

    for (int i = 0; i < 16; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp,
                    5'(i + 3), 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = rand_operand();
      b  = rand_operand();
      run_and_check($sformatf("rand%0d_f%0d", i, f3), f3, a, b, ref_model(f3, a, b),
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    // ALU op and OP-IMM with func7=1 must not start the unit
    seen = 0;
    @(negedge clk);
    bus.opcode_in = OP_R; bus.func7_in = 7'b0000000; bus.func3_in = 3'b000;
    bus.rs1_in = 32'd3; bus.rs2_in = 32'd4;
    for (int i = 0; i < 5; i++) begin
      #1; if (bus.stall_out || bus.busy || bus.result_valid) seen++;
      @(negedge clk);
    end
    bus.opcode_in = 7'b0010011; bus.func7_in = 7'b0000001;
    for (int i = 0; i < 5; i++) begin
      #1; if (bus.stall_out || bus.busy || bus.result_valid) seen++;
      @(negedge clk);
    end
    check("non_m_no_activity", 32'(seen), 32'd0);

    // flush in IDLE suppresses start and stall
    drive_m(3'd0, 32'd9, 32'd9, 5'd4, 1'b1);
    bus.flush = 1'b1;
    #1;
    check("flush_idle_stall", {31'b0, bus.stall_out}, 32'd0);
    @(negedge clk); #1;
    check("flush_idle_busy", {31'b0, bus.busy}, 32'd0);
    bus.flush = 1'b0;
    drive_nop();

    // flush at BUSY counter=10: cycle 1 IDLE, counter 10 in cycle 12
    @(negedge clk);
    drive_m(3'd0, 32'd11, 32'd13, 5'd9, 1'b1);
    #1;
    repeat (11) begin @(negedge clk); #1; end
    check("flush_busy_pre", {31'b0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    @(negedge clk); #1;
    check("flush_busy_state", {31'b0, bus.busy}, 32'd0);
    check("flush_busy_stall", {31'b0, bus.stall_out}, 32'd0);
    bus.flush = 1'b0;
    drive_nop();
    seen = 0;
    repeat (40) begin @(negedge clk); #1; if (bus.result_valid) seen++; end
    check("flush_no_valid", 32'(seen), 32'd0);

    // back-to-back MUL then DIV, one IDLE cycle between the valid pulses
    @(negedge clk);
    drive_m(3'd0, 32'd6, 32'd7, 5'd17, 1'b1);
    #1;
    wait_result(stalls, vcyc, r, ra, re);
    check("b2b_mul_result", r, 32'd42);
    check("b2b_mul_cycle", 32'(vcyc), 32'd34);
    drive_m(3'd4, 32'd1000, 32'd3, 5'd18, 1'b1);
    @(negedge clk); #1;
    check("b2b_gap_valid", {31'b0, bus.result_valid}, 32'd0);
    check("b2b_gap_busy", {31'b0, bus.busy}, 32'd0);
    check("b2b_gap_stall", {31'b0, bus.stall_out}, 32'd1);
    wait_result(stalls, vcyc, r2, ra, re);
    drive_nop();
    check("b2b_div_result", r2, 32'd333);
    check("b2b_div_cycle", 32'(vcyc), 32'd34);
    check("b2b_div_rd", {27'b0, ra}, 32'd18);

    // async reset in the middle of BUSY clears outputs without waiting for a clock
    @(negedge clk);
    drive_m(3'd5, 32'd5000, 32'd7, 5'd21, 1'b1);
    #1;
    repeat (5) begin @(negedge clk); #1; end
    check("arst_pre_busy", {31'b0, bus.busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, bus.busy}, 32'd0);
    check("arst_result", bus.result, 32'd0);
    check("arst_rd_addr", {27'b0, bus.rd_addr_out}, 32'd0);
    check("arst_valid", {31'b0, bus.result_valid}, 32'd0);
    check("arst_rd_en", {31'b0, bus.rd_en_out}, 32'd0);
    drive_nop();
    @(negedge clk);
    rst = 1'b0;
    run_and_check("post_rst", 3'd7, 32'd5000, 32'd7, 32'd2, 5'd22, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
